// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin two-master arbiter for a single memory port with timeout termination.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    i_req,
  input  logic                    i_we,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_wstrb,
  output logic                    i_ack,
  output logic                    i_err,
  output logic [DATA_WIDTH-1:0]   i_rdata,
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_wstrb,
  output logic                    d_ack,
  output logic                    d_err,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    mem_rd,
  output logic                    mem_wr,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic                    mem_ack
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t                state_q;
  logic                  last_d_q;
  logic                  own_d_q;
  logic                  we_q;
  logic [CW-1:0]         cnt_q;
  logic                  pick_d;
  logic                  sel_we;
  logic                  fin;
  logic [DATA_WIDTH-1:0] res;
  // D wins only when I is idle or I was served last
  assign pick_d = d_req & (~i_req | ~last_d_q);
  assign sel_we = pick_d ? d_we : i_we;
  assign fin    = mem_ack | (cnt_q == CW'(TIMEOUT - 1));
  assign res    = (mem_ack & ~we_q) ? mem_rdata : '0;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      last_d_q  <= 1'b1;
      own_d_q   <= 1'b0;
      we_q      <= 1'b0;
      cnt_q     <= '0;
      i_ack     <= 1'b0;
      i_err     <= 1'b0;
      i_rdata   <= '0;
      d_ack     <= 1'b0;
      d_err     <= 1'b0;
      d_rdata   <= '0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      case (state_q)
        IDLE: if (i_req | d_req) begin
          own_d_q   <= pick_d;
          last_d_q  <= pick_d;
          we_q      <= sel_we;
          cnt_q     <= '0;
          mem_rd    <= ~sel_we;
          mem_wr    <= sel_we;
          mem_addr  <= pick_d ? d_addr : i_addr;
          mem_wdata <= pick_d ? d_wdata : i_wdata;
          mem_wstrb <= sel_we ? (pick_d ? d_wstrb : i_wstrb) : '0;
          state_q   <= BUSY;
        end
        BUSY: if (fin) begin
          if (own_d_q) begin
            d_ack   <= 1'b1;
            d_err   <= ~mem_ack;
            d_rdata <= res;
          end else begin
            i_ack   <= 1'b1;
            i_err   <= ~mem_ack;
            i_rdata <= res;
          end
          mem_rd  <= 1'b0;
          mem_wr  <= 1'b0;
          state_q <= DONE;
        end else begin
          cnt_q <= (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench; expected commands/responses queued at stimulus, checked by monitors.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        i_req = 1'b0, i_we = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] i_addr = '0, i_wdata = '0, d_addr = '0, d_wdata = '0;
  logic [3:0]  i_wstrb = '0, d_wstrb = '0;
  logic        i_ack, i_err, d_ack, d_err, mem_rd, mem_wr;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  typedef struct {bit we; logic [31:0] a; logic [31:0] wd; logic [3:0] s;} cmd_t;
  typedef struct {bit d; bit err; logic [31:0] rd;} rsp_t;
  typedef struct {int lat; logic [31:0] rd;} mem_t;
  cmd_t cmd_q[$];
  rsp_t rsp_q[$];
  mem_t mem_q[$];
  int n_cmp = 0, n_bad = 0, last_bc = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(4)) dut (
    .clk(clk), .resetn(resetn),
    .i_req(i_req), .i_we(i_we), .i_addr(i_addr), .i_wdata(i_wdata), .i_wstrb(i_wstrb),
    .i_ack(i_ack), .i_err(i_err), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // lat = BUSY cycle in which memory acks (0 = never); lat beyond TIMEOUT also times out
  task automatic expect_xfer(input bit d, input bit we, input logic [31:0] a, input logic [31:0] wd,
                             input logic [3:0] s, input int lat, input logic [31:0] mrd, input bit acked);
    cmd_q.push_back('{we, a, wd, we ? s : 4'h0});
    mem_q.push_back('{lat, mrd});
    if (acked) rsp_q.push_back('{d, (lat == 0 || lat > 4), (lat == 0 || lat > 4 || we) ? 32'h0 : mrd});
  endtask

  task automatic req(input bit d, input bit we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] s);
    bit got = 0;
    @(negedge clk);
    if (d) begin d_req = 1; d_we = we; d_addr = a; d_wdata = wd; d_wstrb = s; end
    else begin i_req = 1; i_we = we; i_addr = a; i_wdata = wd; i_wstrb = s; end
    for (int k = 0; k < 40 && !got; k++) begin
      @(posedge clk); #1;
      got = d ? d_ack : i_ack;
    end
    if (!got) chk(d ? "d_ack_timeout" : "i_ack_timeout", 0, 1);
    @(negedge clk);
    if (d) d_req = 0; else i_req = 0;
  endtask

  // memory model and command monitor
  initial begin
    int bc = 0;
    mem_t cur = '{1, 32'h0};
    forever begin
      @(posedge clk); #1;
      if (mem_rd || mem_wr) begin
        if (bc == 0) begin
          cmd_t c;
          if (mem_q.size() == 0) begin chk("mem_q_empty", 1, 0); cur = '{1, 32'h0}; end
          else cur = mem_q.pop_front();
          if (cmd_q.size() == 0) chk("cmd_unexpected", 1, 0);
          else begin
            c = cmd_q.pop_front();
            chk("cmd_strobe", {mem_rd, mem_wr}, {~c.we, c.we});
            chk("cmd_addr", mem_addr, c.a);
            chk("cmd_wstrb", mem_wstrb, c.s);
            if (c.we) chk("cmd_wdata", mem_wdata, c.wd);
          end
        end
        bc++;
        last_bc = bc;
        mem_ack = (cur.lat == bc);
        mem_rdata = mem_ack ? cur.rd : 32'hBAD0BAD0;
      end else begin
        bc = 0;
        mem_ack = 0;
        mem_rdata = 32'hBAD0BAD0;
      end
    end
  end

  // response monitor
  initial forever begin
    rsp_t r;
    @(posedge clk); #1;
    if (i_ack && d_ack) chk("both_ack", 1, 0);
    else if (i_ack || d_ack) begin
      if (rsp_q.size() == 0) chk("ack_unexpected", {i_ack, d_ack}, 0);
      else begin
        r = rsp_q.pop_front();
        chk("rsp_owner", d_ack, r.d);
        chk("rsp_err", d_ack ? d_err : i_err, r.err);
        chk("rsp_rdata", d_ack ? d_rdata : i_rdata, r.rd);
      end
    end
  end

  task automatic chk_idle_outputs(input string nm);
    chk({nm, "_acks"}, {i_ack, d_ack, i_err, d_err}, 0);
    chk({nm, "_rdata"}, {i_rdata, d_rdata}, 0);
    chk({nm, "_strobes"}, {mem_rd, mem_wr, mem_wstrb}, 0);
    chk({nm, "_addr_wdata"}, {mem_addr, mem_wdata}, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 chk_idle_outputs("reset");
    @(negedge clk) resetn = 1;
    repeat (2) @(posedge clk);

    // single I read, minimum latency
    expect_xfer(0, 0, 32'h100, 0, 4'hF, 1, 32'hDEADBEEF, 1);
    @(negedge clk);
    i_req = 1; i_we = 0; i_addr = 32'h100; i_wstrb = 4'hF;
    @(posedge clk); #1 chk("t1_mem_rd_c1", mem_rd, 1);
    @(posedge clk); #1 chk("t1_i_ack_c2", {i_ack, i_err, i_rdata}, {1'b1, 1'b0, 32'hDEADBEEF});
    @(negedge clk) i_req = 0;
    @(posedge clk); #1 chk("t1_idle_c3", {i_ack, mem_rd, mem_wr}, 0);
    chk("t1_busy_cycles", last_bc, 1);

    // ties after reset alternate I then D
    @(negedge clk) resetn = 0;
    @(negedge clk) resetn = 1;
    repeat (2) begin
      expect_xfer(0, 0, 32'h10, 0, 4'h0, 2, 32'h11110000, 1);
      expect_xfer(1, 1, 32'h20, 32'h12345678, 4'hF, 1, 32'h0, 1);
      fork
        req(0, 0, 32'h10, 0, 4'h0);
        req(1, 1, 32'h20, 32'h12345678, 4'hF);
      join
    end

    // I kept requesting while D streams: strict alternation
    for (int k = 0; k < 3; k++) begin
      expect_xfer(0, 0, 32'h300 + k, 0, 4'h0, 1 + k, 32'h33330000 + k, 1);
      expect_xfer(1, 1, 32'h400 + k, 32'h44440000 + k, 4'h3 << k, 1, 32'h0, 1);
    end
    fork
      for (int k = 0; k < 3; k++) req(0, 0, 32'h300 + k, 0, 4'h0);
      for (int k = 0; k < 3; k++) req(1, 1, 32'h400 + k, 32'h44440000 + k, 4'h3 << k);
    join

    // ack in the final BUSY cycle beats the timeout
    expect_xfer(1, 0, 32'h50, 0, 4'h0, 4, 32'hA5A5A5A5, 1);
    req(1, 0, 32'h50, 0, 4'h0);
    chk("race_busy_cycles", last_bc, 4);

    // no ack at all: error termination with zero data
    expect_xfer(1, 0, 32'h40, 0, 4'h0, 0, 32'h0, 1);
    req(1, 0, 32'h40, 0, 4'h0);
    chk("timeout_busy_cycles", last_bc, 4);
    chk("timeout_strobes_low", {mem_rd, mem_wr}, 0);
    chk("i_side_held", {i_err, i_rdata}, {1'b0, 32'h33330002});

    // reset during BUSY aborts with no ack
    expect_xfer(0, 0, 32'h60, 0, 4'h0, 0, 32'h0, 0);
    @(negedge clk);
    i_req = 1; i_we = 0; i_addr = 32'h60;
    repeat (2) @(posedge clk);
    @(negedge clk) resetn = 0;
    #1 chk("abort_mem_rd", mem_rd, 0);
    chk_idle_outputs("abort");
    i_req = 0;
    repeat (8) @(posedge clk);
    @(negedge clk) resetn = 1;
    expect_xfer(0, 0, 32'h70, 0, 4'h0, 1, 32'h77777777, 1);
    expect_xfer(1, 0, 32'h80, 0, 4'h0, 3, 32'h88888888, 1);
    fork
      req(0, 0, 32'h70, 0, 4'h0);
      req(1, 0, 32'h80, 0, 4'h0);
    join

    repeat (4) @(posedge clk);
    #1 chk("rsp_q_drained", rsp_q.size(), 0);
    chk("cmd_q_drained", cmd_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1);
  end
endmodule
